// File: rtl/lora_pkg.sv
// Shared definitions for the LoRa frame receiver: sync byte, payload bit
// positions and the state encodings of the parser and the UART deserializer.
package lora_pkg;

    localparam logic [7:0] LORA_SYNC = 8'hAA;

    localparam int LED_BIT  = 7;
    localparam int RGB_BIT  = 6;
    localparam int BELL_BIT = 5;
    localparam int MODE_HI  = 4;
    localparam int MODE_LO  = 2;

    typedef enum logic [1:0] {
        ST_HDR = 2'd0,
        ST_PAY = 2'd1,
        ST_TRL = 2'd2
    } parse_state_t;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } uart_state_t;

    // A payload byte carries its flags in [7:2]; the two low bits must be zero.
    function automatic logic payload_ok(input logic [7:0] b);
        return b[1:0] == 2'b00;
    endfunction

endpackage

// File: rtl/lora_frame_rx_uart_rx.sv
// 8N1 UART deserializer driven by a 16x oversample tick; emits a one-cycle
// rx_done_tick with the received byte once the stop bit has been sampled.
module uart_rx
    import lora_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    input  logic       s_tick,
    output logic [7:0] dout,
    output logic       rx_done_tick
);

    uart_state_t state;
    logic [3:0]  s_cnt;
    logic [2:0]  n_cnt;
    logic [7:0]  shreg;
    logic        rx_prev;

    // Start bit sampled mid-bit at tick 7, every later bit 16 ticks after the previous sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= RX_IDLE;
            s_cnt        <= 4'd0;
            n_cnt        <= 3'd0;
            shreg        <= 8'd0;
            rx_prev      <= 1'b1;
            rx_done_tick <= 1'b0;
        end else begin
            rx_prev      <= rx;
            rx_done_tick <= 1'b0;
            case (state)
                RX_IDLE: begin
                    if (rx_prev && !rx) begin
                        state <= RX_START;
                        s_cnt <= 4'd0;
                    end
                end
                RX_START: begin
                    if (s_tick) begin
                        if (s_cnt == 4'd7) begin
                            state <= RX_DATA;
                            s_cnt <= 4'd0;
                            n_cnt <= 3'd0;
                        end else begin
                            s_cnt <= s_cnt + 4'd1;
                        end
                    end
                end
                RX_DATA: begin
                    if (s_tick) begin
                        if (s_cnt == 4'd15) begin
                            s_cnt <= 4'd0;
                            shreg <= {rx, shreg[7:1]};
                            if (n_cnt == 3'd7) begin
                                state <= RX_STOP;
                            end else begin
                                n_cnt <= n_cnt + 3'd1;
                            end
                        end else begin
                            s_cnt <= s_cnt + 4'd1;
                        end
                    end
                end
                RX_STOP: begin
                    if (s_tick) begin
                        if (s_cnt == 4'd15) begin
                            state        <= RX_IDLE;
                            s_cnt        <= 4'd0;
                            rx_done_tick <= 1'b1;
                        end else begin
                            s_cnt <= s_cnt + 4'd1;
                        end
                    end
                end
                default: state <= RX_IDLE;
            endcase
        end
    end

    assign dout = shreg;

endmodule

// File: rtl/lora_frame_rx.sv
// LoRa control-frame receiver: AA / payload / AA over 8N1 UART, committing
// led/rgb/bell/rgb_mode on a good trailer. Define LORA_RX_TIMEOUT_EN for an inter-byte timeout.
module lora_frame_rx
    import lora_pkg::*;
#(
    parameter int BAUD_DIV = 651,
    parameter int TIMEOUT  = 10_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       lora_rx,
    output logic       bell,
    output logic       led,
    output logic       rgb,
    output logic [2:0] rgb_mode,
    output logic       frame_tick,
    output logic       err_tick
);

    localparam int BW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

    logic [BW-1:0]         baud_cnt;
    logic                  s_tick;
    logic                  rx_meta;
    logic                  rx_sync;
    logic [7:0]            rx_byte;
    logic                  rx_done;
    logic                  timeout_hit;
    parse_state_t          state;
    logic [LED_BIT:MODE_LO] staged;

    assign s_tick = (baud_cnt == BW'(BAUD_DIV - 1));

    // Free-running oversample divider plus the two-flop synchronizer on the serial line.
    always_ff @(posedge clk) begin
        if (rst) begin
            baud_cnt <= '0;
            rx_meta  <= 1'b1;
            rx_sync  <= 1'b1;
        end else begin
            baud_cnt <= s_tick ? '0 : baud_cnt + 1'b1;
            rx_meta  <= lora_rx;
            rx_sync  <= rx_meta;
        end
    end

    uart_rx u_uart_rx (
        .clk          (clk),
        .rst          (rst),
        .rx           (rx_sync),
        .s_tick       (s_tick),
        .dout         (rx_byte),
        .rx_done_tick (rx_done)
    );

`ifdef LORA_RX_TIMEOUT_EN
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [TW-1:0] to_cnt;

    // An arriving byte always wins over a simultaneous expiry.
    assign timeout_hit = !rx_done && (state != ST_HDR) && (to_cnt == TW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst || rx_done || state == ST_HDR || timeout_hit) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // Parser: a bad payload that is itself a sync byte is treated as a fresh header.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_HDR;
            staged     <= '0;
            bell       <= 1'b0;
            led        <= 1'b0;
            rgb        <= 1'b0;
            rgb_mode   <= 3'b000;
            frame_tick <= 1'b0;
            err_tick   <= 1'b0;
        end else begin
            frame_tick <= 1'b0;
            err_tick   <= 1'b0;
            if (rx_done) begin
                case (state)
                    ST_HDR: begin
                        if (rx_byte == LORA_SYNC) state <= ST_PAY;
                    end
                    ST_PAY: begin
                        if (payload_ok(rx_byte)) begin
                            staged <= rx_byte[LED_BIT:MODE_LO];
                            state  <= ST_TRL;
                        end else begin
                            err_tick <= 1'b1;
                            state    <= (rx_byte == LORA_SYNC) ? ST_PAY : ST_HDR;
                        end
                    end
                    ST_TRL: begin
                        if (rx_byte == LORA_SYNC) begin
                            led        <= staged[LED_BIT];
                            rgb        <= staged[RGB_BIT];
                            bell       <= staged[BELL_BIT];
                            rgb_mode   <= staged[MODE_HI:MODE_LO];
                            frame_tick <= 1'b1;
                        end else begin
                            err_tick <= 1'b1;
                        end
                        state <= ST_HDR;
                    end
                    default: state <= ST_HDR;
                endcase
            end else if (timeout_hit) begin
                err_tick <= 1'b1;
                state    <= ST_HDR;
            end
        end
    end

endmodule

// File: tb/tb_lora_frame_rx.sv
// Scoreboard bench for lora_frame_rx: serial frames are driven on lora_rx and
// every frame_tick/err_tick is matched against the queue of expected events.
module tb_lora_frame_rx;

    localparam int BAUD_DIV = 4;
    localparam int TIMEOUT  = 1000;
    localparam int BIT_CLKS = 16 * BAUD_DIV;

    typedef struct packed {
        logic       is_err;
        logic       led;
        logic       rgb;
        logic       bell;
        logic [2:0] mode;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       lora_rx = 1'b1;
    logic       bell, led, rgb;
    logic [2:0] rgb_mode;
    logic       frame_tick, err_tick;

    int  pass_cnt  = 0;
    int  total_cnt = 0;
    ev_t sb[$];

    logic       m_led = 1'b0, m_rgb = 1'b0, m_bell = 1'b0;
    logic [2:0] m_mode = 3'b000;

    lora_frame_rx #(.BAUD_DIV(BAUD_DIV), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .rst        (rst),
        .lora_rx    (lora_rx),
        .bell       (bell),
        .led        (led),
        .rgb        (rgb),
        .rgb_mode   (rgb_mode),
        .frame_tick (frame_tick),
        .err_tick   (err_tick)
    );

    always #5 clk = ~clk;

    // Every tick the DUT raises must match the oldest outstanding expectation.
    always @(negedge clk) begin : monitor
        ev_t got;
        ev_t exp;
        if (!rst && (frame_tick || err_tick)) begin
            got = '{is_err: err_tick, led: led, rgb: rgb, bell: bell, mode: rgb_mode};
            total_cnt++;
            if (frame_tick && err_tick) begin
                $display("[TB] FAIL tick_overlap: frame_tick=%b err_tick=%b, required not both", frame_tick, err_tick);
            end else if (sb.size() == 0) begin
                $display("[TB] FAIL unexpected_event: got %h, required no event", got);
            end else begin
                exp = sb.pop_front();
                if (got !== exp) begin
                    $display("[TB] FAIL event: got {err,led,rgb,bell,mode}=%h, required %h", got, exp);
                end else begin
                    pass_cnt++;
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap_bits);
        logic [9:0] frame;
        frame = {1'b1, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            lora_rx = frame[i];
            repeat (BIT_CLKS) @(negedge clk);
        end
        lora_rx = 1'b1;
        repeat (gap_bits * BIT_CLKS) @(negedge clk);
    endtask

    task automatic expect_frame(input logic [7:0] payload);
        m_led  = payload[7];
        m_rgb  = payload[6];
        m_bell = payload[5];
        m_mode = payload[4:2];
        sb.push_back('{is_err: 1'b0, led: m_led, rgb: m_rgb, bell: m_bell, mode: m_mode});
    endtask

    task automatic expect_err();
        sb.push_back('{is_err: 1'b1, led: m_led, rgb: m_rgb, bell: m_bell, mode: m_mode});
    endtask

    task automatic test_reset();
        rst = 1'b1;
        lora_rx = 1'b1;
        repeat (5) @(negedge clk);
        total_cnt++;
        if ({led, rgb, bell, rgb_mode} !== 6'b0) $display("[TB] FAIL reset_outputs: got %b, required 000000", {led, rgb, bell, rgb_mode});
        else pass_cnt++;
        total_cnt++;
        if ({frame_tick, err_tick} !== 2'b00) $display("[TB] FAIL reset_ticks: got %b, required 00", {frame_tick, err_tick});
        else pass_cnt++;
        rst = 1'b0;
        repeat (2 * BIT_CLKS) @(negedge clk);
        total_cnt++;
        if ({led, rgb, bell, rgb_mode, frame_tick, err_tick} !== 8'b0) $display("[TB] FAIL idle_after_reset: got %b, required 00000000", {led, rgb, bell, rgb_mode, frame_tick, err_tick});
        else pass_cnt++;
    endtask

    task automatic test_basic();
        send_byte(8'hAA, 1);
        send_byte(8'hA8, 1);
        expect_frame(8'hA8);
        send_byte(8'hAA, 1);
        repeat (20) @(negedge clk);
        total_cnt++;
        if (sb.size() != 0) $display("[TB] FAIL basic_drain: %0d events pending, required 0", sb.size());
        else pass_cnt++;
        total_cnt++;
        if ({led, rgb, bell, rgb_mode} !== 6'b101_010) $display("[TB] FAIL basic_outputs: got %b, required 101010", {led, rgb, bell, rgb_mode});
        else pass_cnt++;
    endtask

    task automatic test_noise_drop();
        send_byte(8'h55, 1);
        send_byte(8'h13, 1);
        send_byte(8'hAA, 1);
        send_byte(8'h64, 1);
        expect_frame(8'h64);
        send_byte(8'hAA, 1);
        repeat (20) @(negedge clk);
        total_cnt++;
        if (sb.size() != 0) $display("[TB] FAIL noise_drain: %0d events pending, required 0", sb.size());
        else pass_cnt++;
        total_cnt++;
        if ({led, rgb, bell, rgb_mode} !== 6'b011_001) $display("[TB] FAIL noise_outputs: got %b, required 011001", {led, rgb, bell, rgb_mode});
        else pass_cnt++;
    endtask

    task automatic test_resync();
        send_byte(8'hAA, 1);
        expect_err();
        send_byte(8'hA9, 1);
        send_byte(8'hAA, 1);
        expect_err();
        send_byte(8'hAA, 1);
        send_byte(8'h1C, 1);
        expect_frame(8'h1C);
        send_byte(8'hAA, 1);
        repeat (20) @(negedge clk);
        total_cnt++;
        if (sb.size() != 0) $display("[TB] FAIL resync_drain: %0d events pending, required 0", sb.size());
        else pass_cnt++;
        total_cnt++;
        if ({led, rgb, bell, rgb_mode} !== 6'b000_111) $display("[TB] FAIL resync_outputs: got %b, required 000111", {led, rgb, bell, rgb_mode});
        else pass_cnt++;
    endtask

    task automatic test_bad_trailer();
        send_byte(8'hAA, 1);
        send_byte(8'hA8, 1);
        expect_err();
        send_byte(8'h55, 1);
        repeat (20) @(negedge clk);
        total_cnt++;
        if (sb.size() != 0) $display("[TB] FAIL trailer_drain: %0d events pending, required 0", sb.size());
        else pass_cnt++;
        total_cnt++;
        if ({led, rgb, bell, rgb_mode} !== 6'b000_111) $display("[TB] FAIL trailer_hold: got %b, required 000111", {led, rgb, bell, rgb_mode});
        else pass_cnt++;
    endtask

    task automatic test_timeout();
        send_byte(8'hAA, 0);
`ifdef LORA_RX_TIMEOUT_EN
        expect_err();
        repeat (1200) @(negedge clk);
        total_cnt++;
        if (sb.size() != 0) $display("[TB] FAIL timeout_err: %0d events pending, required 0", sb.size());
        else pass_cnt++;
        send_byte(8'hAA, 1);
`else
        repeat (1500) @(negedge clk);
`endif
        send_byte(8'hA8, 1);
        expect_frame(8'hA8);
        send_byte(8'hAA, 1);
        repeat (20) @(negedge clk);
        total_cnt++;
        if (sb.size() != 0) $display("[TB] FAIL timeout_drain: %0d events pending, required 0", sb.size());
        else pass_cnt++;
        total_cnt++;
        if ({led, rgb, bell, rgb_mode} !== 6'b101_010) $display("[TB] FAIL timeout_outputs: got %b, required 101010", {led, rgb, bell, rgb_mode});
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] partial;
        partial = 8'hA8;
        send_byte(8'hAA, 1);
        lora_rx = 1'b0;
        repeat (BIT_CLKS) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            lora_rx = partial[i];
            repeat (BIT_CLKS) @(negedge clk);
        end
        repeat (BIT_CLKS / 2) @(negedge clk);
        rst = 1'b1;
        lora_rx = 1'b1;
        repeat (3) @(negedge clk);
        total_cnt++;
        if ({led, rgb, bell, rgb_mode} !== 6'b0) $display("[TB] FAIL midreset_outputs: got %b, required 000000", {led, rgb, bell, rgb_mode});
        else pass_cnt++;
        m_led = 1'b0; m_rgb = 1'b0; m_bell = 1'b0; m_mode = 3'b000;
        rst = 1'b0;
        repeat (2 * BIT_CLKS) @(negedge clk);
        send_byte(8'hAA, 1);
        send_byte(8'hA8, 1);
        expect_frame(8'hA8);
        send_byte(8'hAA, 1);
        repeat (20) @(negedge clk);
        total_cnt++;
        if (sb.size() != 0) $display("[TB] FAIL midreset_drain: %0d events pending, required 0", sb.size());
        else pass_cnt++;
        total_cnt++;
        if ({led, rgb, bell, rgb_mode} !== 6'b101_010) $display("[TB] FAIL midreset_outputs_after: got %b, required 101010", {led, rgb, bell, rgb_mode});
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        send_byte(8'hAA, 0);
        send_byte(8'h64, 0);
        expect_frame(8'h64);
        send_byte(8'hAA, 0);
        send_byte(8'hAA, 0);
        send_byte(8'hFC, 0);
        expect_frame(8'hFC);
        send_byte(8'hAA, 1);
        repeat (20) @(negedge clk);
        total_cnt++;
        if (sb.size() != 0) $display("[TB] FAIL b2b_drain: %0d events pending, required 0", sb.size());
        else pass_cnt++;
        total_cnt++;
        if ({led, rgb, bell, rgb_mode} !== 6'b111_111) $display("[TB] FAIL b2b_outputs: got %b, required 111111", {led, rgb, bell, rgb_mode});
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_noise_drop();
        test_resync();
        test_bad_trailer();
        test_timeout();
        test_reset_mid_frame();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/lora_frame_rx.md
LORA_FRAME_RX -- requirements
Module: lora_frame_rx

Interface
REQ-001 SHALL have parameter BAUD_DIV, default 651: system clocks per 16x-oversample tick, giving 9600 baud at 100 MHz.
REQ-002 SHALL have parameter TIMEOUT, default 10_000_000: inter-byte timeout in clocks, 100 ms at 100 MHz.
REQ-003 SHALL have port clk  input  1  system clock; the block uses one clock.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port lora_rx  input  1  UART serial line from the LoRa module; idles high; 8N1.
REQ-006 SHALL have port bell  output  1  last committed bell bit.
REQ-007 SHALL have port led  output  1  last committed led bit.
REQ-008 SHALL have port rgb  output  1  last committed rgb bit.
REQ-009 SHALL have port rgb_mode  output  3  last committed RGB mode.
REQ-010 SHALL have port frame_tick  output  1  one-cycle pulse when a valid frame is committed.
REQ-011 SHALL have port err_tick  output  1  one-cycle pulse when a frame is aborted.

Function
REQ-012 SHALL accept the frame format 0xAA (header), payload {led,rgb,bell,rgb_mode[2:0],2'b00}, 0xAA (trailer), with bytes sent LSB first.
REQ-013 SHALL run a parser FSM with states ST_HDR, ST_PAY and ST_TRL, acting only on the byte-done pulse from the UART receiver.
REQ-014 In ST_HDR: byte 0xAA -> ST_PAY; any other byte is discarded silently and the FSM stays in ST_HDR with no err_tick.
REQ-015 In ST_PAY: if byte[1:0]==2'b00, stage the byte and go to ST_TRL.
REQ-016 In ST_PAY: if byte[1:0]!=2'b00, pulse err_tick; if the byte is 0xAA, stay in ST_PAY (resync as a new header), otherwise go to ST_HDR.
REQ-017 In ST_TRL: byte 0xAA -> commit the staged payload to bell/led/rgb/rgb_mode, pulse frame_tick, go to ST_HDR.
REQ-018 In ST_TRL: any other byte -> pulse err_tick, go to ST_HDR; outputs stay unchanged.
REQ-019 SHALL update outputs and assert frame_tick together, exactly 1 clk after the byte-done pulse of the trailer byte.
REQ-020 SHALL hold the committed outputs until the next valid commit or reset; an aborted frame never alters them.
REQ-021 frame_tick and err_tick SHALL never be asserted in the same cycle.
REQ-022 The UART receiver SHALL detect a start bit on a falling edge of lora_rx.
REQ-023 The UART receiver SHALL sample each bit at oversample tick 7 of 16 (start bit) and at tick 15 of each subsequent 16-tick bit period.
REQ-024 The UART receiver SHALL end the byte after 16 stop-bit ticks, and SHALL then emit a 1-clk byte-done pulse with the 8-bit data.
REQ-025 SHALL double-register lora_rx before use.
REQ-026 SHALL generate the oversample tick with a free-running counter of 0..BAUD_DIV-1, asserting the tick when the count equals BAUD_DIV-1.

Reset
REQ-027 While rst is high at a clk edge: FSM -> ST_HDR; bell, led, rgb, rgb_mode, frame_tick and err_tick -> 0.
REQ-028 While rst is high at a clk edge: staging register, timeout counter, baud counter and UART receiver state -> 0/idle.
REQ-029 A reset asserted mid-frame SHALL discard the partial frame with no err_tick; parsing restarts at ST_HDR on the next byte.

Configuration
REQ-030 With macro LORA_RX_TIMEOUT_EN defined, a counter SHALL clear on every byte-done pulse and while in ST_HDR.
REQ-031 With LORA_RX_TIMEOUT_EN defined, in ST_PAY or ST_TRL, reaching TIMEOUT-1 counts without a byte SHALL pulse err_tick and return the FSM to ST_HDR.
REQ-032 If a byte-done pulse arrives in the same cycle as the timeout expiry, the byte SHALL take priority and the timeout SHALL be ignored.
REQ-033 Without LORA_RX_TIMEOUT_EN, no timeout counter SHALL exist; the FSM waits indefinitely in ST_PAY/ST_TRL.

Structure
REQ-034 A shared package lora_pkg SHALL hold LORA_SYNC = 8'haa, the FSM state encoding, and the payload bit positions (LED 7, RGB 6, BELL 5, MODE 4:2).
REQ-035 The serial deserializer SHALL be one sub-module, uart_rx, with ports clk, rst, rx, s_tick, dout[7:0] and rx_done_tick.
REQ-036 The baud counter and parser FSM SHALL reside in lora_frame_rx.

Verification
REQ-037 Bench SHALL cover: serial AA,A8,AA -> after the trailer, led=1, rgb=0, bell=1, rgb_mode=3'b010, and one frame_tick.
REQ-038 Bench SHALL cover: bytes 55,13,AA,64,AA -> 55 and 13 dropped without err_tick; outputs led=0, rgb=1, bell=1, rgb_mode=3'b001; one frame_tick.
REQ-039 Bench SHALL cover: AA,A9,… -> err_tick on A9, FSM in ST_HDR; then AA,AA,1C,AA -> second AA errors and resyncs; rgb_mode=3'b111, bell=0.
REQ-040 Bench SHALL cover: AA,A8,55 -> err_tick on 55; outputs unchanged from the previous frame; no frame_tick.
REQ-041 Bench SHALL cover (LORA_RX_TIMEOUT_EN, TIMEOUT=1000): AA then 1000 idle clks -> a single err_tick; a following AA,A8,AA is accepted normally.
REQ-042 Bench SHALL cover: rst asserted mid-payload bit, then AA,A8,AA -> no err_tick, outputs 0 during reset, frame committed correctly afterwards.
